// File: rtl/usb_fifo_drain.sv
// Drains the async sample FIFO into the FX2 slave-FIFO bus through a 2-entry skid buffer,
// committing short packets to the host on an idle timeout or when streaming is disabled.
module usb_fifo_drain #(
  parameter int DATA_WIDTH     = 8,
  parameter int PKT_BYTES      = 512,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int PKTCNT_WIDTH   = 16
) (
  input  logic                    rdclk,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [DATA_WIDTH-1:0]   fifo_q,
  input  logic                    fifo_rdempty,
  output logic                    fifo_rdreq,
  input  logic                    usb_full_n,
  output logic [DATA_WIDTH-1:0]   usb_fd,
  output logic                    usb_slwr_n,
  output logic                    usb_pktend_n,
  output logic [PKTCNT_WIDTH-1:0] pkt_count,
  output logic                    busy
);

  localparam int BC_W = $clog2(PKT_BYTES);
  localparam int IC_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(PKT_BYTES - 1);
  localparam logic [IC_W-1:0] IC_MAX  = IC_W'(TIMEOUT_CYCLES);
  localparam logic [IC_W-1:0] IC_FIRE = IC_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {STREAM, PKTEND} state_t;

  state_t                  state;
  logic [1:0]              occ;
  logic                    rd_d1;
  logic [BC_W-1:0]         byte_cnt;
  logic [IC_W-1:0]         idle_cnt;
  logic [DATA_WIDTH-1:0]   skid_head;
  logic [DATA_WIDTH-1:0]   skid_tail;

  logic                    pop;
  logic                    capture;
  logic                    accept;
  logic                    flush_go;
  logic [2:0]              fill_next;

  function automatic logic [IC_W-1:0] idle_step(input logic [IC_W-1:0] cnt);
    return (cnt >= IC_MAX) ? IC_MAX : cnt + 1'b1;
  endfunction

  // A read is only issued if the buffer can still hold it once the in-flight read lands.
  assign pop        = (occ != 2'd0) & usb_full_n & (state == STREAM);
  assign capture    = rd_d1;
  assign fill_next  = {1'b0, occ} + {2'b00, rd_d1} - {2'b00, pop};
  assign fifo_rdreq = ~clear & enable & (state == STREAM) & ~fifo_rdempty & (fill_next < 3'd2);
  assign accept     = fifo_rdreq & ~fifo_rdempty;

  assign flush_go = (state == STREAM) & (byte_cnt != '0) & (occ == 2'd0) & ~rd_d1 & ~fifo_rdreq &
                    ((idle_cnt == IC_FIRE) | ~enable);

  assign busy = (occ != 2'd0) | rd_d1 | (byte_cnt != '0) | (state == PKTEND);

  // Stage p1: skid buffer storage, head is always the oldest byte.
  always_ff @(posedge rdclk) begin
    if (pop && occ == 2'd2)
      skid_head <= skid_tail;
    else if (capture && (occ == 2'd0 || (occ == 2'd1 && pop)))
      skid_head <= fifo_q;
    if (capture && ((occ == 2'd2 && pop) || (occ == 2'd1 && !pop)))
      skid_tail <= fifo_q;
  end

  // Stage p2: bus strobes, packet accounting and the commit state machine.
  always_ff @(posedge rdclk) begin
    if (clear) begin
      state        <= STREAM;
      occ          <= 2'd0;
      rd_d1        <= 1'b0;
      byte_cnt     <= '0;
      idle_cnt     <= '0;
      usb_fd       <= '0;
      usb_slwr_n   <= 1'b1;
      usb_pktend_n <= 1'b1;
      pkt_count    <= '0;
    end else begin
      assert (!(capture && occ == 2'd2));
      rd_d1        <= accept;
      occ          <= fill_next[1:0];
      usb_slwr_n   <= ~pop;
      usb_pktend_n <= 1'b1;
      if (pop)
        usb_fd <= skid_head;

      if (state == STREAM) begin
        if (pop) begin
          byte_cnt <= byte_cnt + 1'b1;
          if (byte_cnt == BC_LAST)
            pkt_count <= pkt_count + 1'b1;
        end
        if (pop || capture)
          idle_cnt <= '0;
        else
          idle_cnt <= idle_step(idle_cnt);
        if (flush_go)
          state <= PKTEND;
      end else if (usb_full_n) begin
        usb_pktend_n <= 1'b0;
        byte_cnt     <= '0;
        idle_cnt     <= '0;
        pkt_count    <= pkt_count + 1'b1;
        state        <= STREAM;
      end
    end
  end

endmodule

// File: tb/tb_usb_fifo_drain.sv
// Directed bench for usb_fifo_drain: a behavioural FIFO feeds the block and a negedge
// monitor records every FX2 write and packet-end strobe for the per-scenario tasks.
module tb_usb_fifo_drain;

  localparam int DW = 8;
  localparam int PB = 512;
  localparam int TO = 1024;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          clear = 1'b1;
  logic          enable = 1'b1;
  logic          usb_full_n = 1'b1;
  logic [DW-1:0] fifo_q = '0;
  logic          fifo_rdempty;
  logic          fifo_rdreq;
  logic [DW-1:0] usb_fd;
  logic          usb_slwr_n;
  logic          usb_pktend_n;
  logic [PW-1:0] pkt_count;
  logic          busy;

  always #5 clk = ~clk;

  usb_fifo_drain #(
    .DATA_WIDTH(DW), .PKT_BYTES(PB), .TIMEOUT_CYCLES(TO), .PKTCNT_WIDTH(PW)
  ) dut (
    .rdclk(clk), .clear(clear), .enable(enable), .fifo_q(fifo_q),
    .fifo_rdempty(fifo_rdempty), .fifo_rdreq(fifo_rdreq), .usb_full_n(usb_full_n),
    .usb_fd(usb_fd), .usb_slwr_n(usb_slwr_n), .usb_pktend_n(usb_pktend_n),
    .pkt_count(pkt_count), .busy(busy)
  );

  // Behavioural FIFO with one-cycle read latency.
  logic [DW-1:0] fmem [0:4095];
  int wp = 0;
  int rp = 0;
  assign fifo_rdempty = (rp == wp);

  always @(posedge clk) begin
    if (fifo_rdreq && !fifo_rdempty) begin
      fifo_q <= fmem[rp[11:0]];
      rp     <= rp + 1;
    end
  end

  // Bus monitor, sampled on the falling edge.
  int            cyc = 0;
  int            wr_cnt = 0;
  int            pk_low = 0;
  int            pk_pulses = 0;
  int            pk_cyc = 0;
  int            ovl = 0;
  logic          pk_prev = 1'b1;
  logic [DW-1:0] wr_data [0:4095];
  int            wr_cyc  [0:4095];
  logic [PW-1:0] wr_pc   [0:4095];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (usb_slwr_n === 1'b0) begin
      wr_data[wr_cnt[11:0]] <= usb_fd;
      wr_cyc[wr_cnt[11:0]]  <= cyc + 1;
      wr_pc[wr_cnt[11:0]]   <= pkt_count;
      wr_cnt                <= wr_cnt + 1;
    end
    if (usb_pktend_n === 1'b0) begin
      pk_low <= pk_low + 1;
      pk_cyc <= cyc + 1;
      if (pk_prev === 1'b1)
        pk_pulses <= pk_pulses + 1;
    end
    pk_prev <= usb_pktend_n;
    if (usb_slwr_n === 1'b0 && usb_pktend_n === 1'b0)
      ovl <= ovl + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic push_seq(input int n, input int off);
    for (int i = 0; i < n; i++) begin
      fmem[wp[11:0]] = 8'((off + i) & 255);
      wp = wp + 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    clear = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic wait_wr(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (wr_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_pk(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (pk_pulses >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear = 1'b1; enable = 1'b1; usb_full_n = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    checks++; if (usb_slwr_n !== 1'b1) begin failures++; $display("FAIL reset_slwr got=%b exp=1", usb_slwr_n); end
    checks++; if (usb_pktend_n !== 1'b1) begin failures++; $display("FAIL reset_pktend got=%b exp=1", usb_pktend_n); end
    checks++; if (usb_fd !== 8'd0) begin failures++; $display("FAIL reset_fd got=%h exp=00", usb_fd); end
    checks++; if (pkt_count !== 16'd0) begin failures++; $display("FAIL reset_pktcount got=%0d exp=0", pkt_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fifo_rdreq !== 1'b0) begin failures++; $display("FAIL reset_rdreq got=%b exp=0", fifo_rdreq); end
    clear = 1'b0;
  endtask

  task automatic test_stream_600();
    int b, p, pl, bad;
    bit ok;
    do_reset();
    enable = 1'b1; usb_full_n = 1'b1;
    b = wr_cnt; p = pk_pulses; pl = pk_low;
    push_seq(600, 0);
    wait_wr(b + 600, 1500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL s600_writes got=%0d exp=600", wr_cnt - b); end
    bad = 0;
    for (int i = 0; i < 600; i++) if (wr_data[b + i] !== 8'(i & 255)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL s600_order bad_bytes=%0d exp=0", bad); end
    checks++; if (wr_pc[b + 510] !== 16'd0) begin failures++; $display("FAIL s600_pc_511 got=%0d exp=0", wr_pc[b + 510]); end
    checks++; if (wr_pc[b + 511] !== 16'd1) begin failures++; $display("FAIL s600_pc_512 got=%0d exp=1", wr_pc[b + 511]); end
    checks++; if (pkt_count !== 16'd1 || busy !== 1'b1) begin failures++; $display("FAIL s600_partial pkt=%0d busy=%b exp=1/1", pkt_count, busy); end
    wait_pk(p + 1, TO + 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL s600_pktend_seen got=0 exp=1"); end
    checks++; if (pk_cyc - wr_cyc[b + 599] != TO + 1) begin failures++; $display("FAIL s600_timeout_delay got=%0d exp=%0d", pk_cyc - wr_cyc[b + 599], TO + 1); end
    @(negedge clk); #1;
    checks++; if (pkt_count !== 16'd2) begin failures++; $display("FAIL s600_pktcount got=%0d exp=2", pkt_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL s600_busy got=%b exp=0", busy); end
    checks++; if (pk_low - pl != 1) begin failures++; $display("FAIL s600_pktend_width got=%0d exp=1", pk_low - pl); end
    checks++; if (wr_cnt - b != 600) begin failures++; $display("FAIL s600_total got=%0d exp=600", wr_cnt - b); end
  endtask

  task automatic test_throughput();
    int b, c0, bad;
    bit ok;
    do_reset();
    enable = 1'b0; usb_full_n = 1'b1;
    b = wr_cnt;
    push_seq(20, 50);
    @(negedge clk); #1;
    c0 = cyc;
    enable = 1'b1;
    wait_wr(b + 20, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL tput_writes got=%0d exp=20", wr_cnt - b); end
    checks++; if (wr_cyc[b] != c0 + 3) begin failures++; $display("FAIL tput_latency got=%0d exp=3", wr_cyc[b] - c0); end
    checks++; if (wr_cyc[b + 19] != wr_cyc[b] + 19) begin failures++; $display("FAIL tput_span got=%0d exp=19", wr_cyc[b + 19] - wr_cyc[b]); end
    bad = 0;
    for (int i = 0; i < 20; i++) if (wr_data[b + i] !== 8'(50 + i)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL tput_order bad_bytes=%0d exp=0", bad); end
  endtask

  task automatic test_backpressure();
    int b, n0, r0, bad;
    bit ok;
    do_reset();
    enable = 1'b1; usb_full_n = 1'b1;
    b = wr_cnt; r0 = rp;
    push_seq(40, 100);
    wait_wr(b + 10, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_first10 got=%0d exp=10", wr_cnt - b); end
    usb_full_n = 1'b0;
    n0 = wr_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (i == 4) begin
        checks++; if (fifo_rdreq !== 1'b0) begin failures++; $display("FAIL bp_rdreq got=%b exp=0", fifo_rdreq); end
        checks++; if (rp - r0 != 12) begin failures++; $display("FAIL bp_reads got=%0d exp=12", rp - r0); end
      end
    end
    checks++; if (wr_cnt != n0) begin failures++; $display("FAIL bp_no_writes got=%0d exp=0", wr_cnt - n0); end
    usb_full_n = 1'b1;
    wait_wr(b + 40, 200, ok);
    repeat (3) @(negedge clk); #1;
    checks++; if (wr_cnt - b != 40) begin failures++; $display("FAIL bp_total got=%0d exp=40", wr_cnt - b); end
    bad = 0;
    for (int i = 0; i < 40; i++) if (wr_data[b + i] !== 8'(100 + i)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_order bad_bytes=%0d exp=0", bad); end
  endtask

  task automatic test_disable_flush();
    int b, p, pl, bad;
    bit ok;
    do_reset();
    enable = 1'b1; usb_full_n = 1'b1;
    b = wr_cnt; p = pk_pulses; pl = pk_low;
    push_seq(5, 200);
    wait_wr(b + 5, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL dis_writes got=%0d exp=5", wr_cnt - b); end
    enable = 1'b0;
    wait_pk(p + 1, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL dis_pktend_seen got=0 exp=1"); end
    checks++; if (pk_cyc != wr_cyc[b + 4] + 2) begin failures++; $display("FAIL dis_pktend_delay got=%0d exp=2", pk_cyc - wr_cyc[b + 4]); end
    @(negedge clk); #1;
    checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL dis_pktcount got=%0d exp=1", pkt_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dis_busy got=%b exp=0", busy); end
    checks++; if (pk_low - pl != 1) begin failures++; $display("FAIL dis_pktend_width got=%0d exp=1", pk_low - pl); end
    bad = 0;
    for (int i = 0; i < 5; i++) if (wr_data[b + i] !== 8'(200 + i)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL dis_order bad_bytes=%0d exp=0", bad); end
  endtask

  task automatic test_exact_packet();
    int b, p;
    bit ok;
    do_reset();
    enable = 1'b1; usb_full_n = 1'b1;
    b = wr_cnt; p = pk_pulses;
    push_seq(512, 7);
    wait_wr(b + 512, 800, ok);
    checks++; if (!ok) begin failures++; $display("FAIL exact_writes got=%0d exp=512", wr_cnt - b); end
    repeat (2 * TO) @(negedge clk);
    #1;
    checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL exact_pktcount got=%0d exp=1", pkt_count); end
    checks++; if (pk_pulses != p) begin failures++; $display("FAIL exact_no_pktend got=%0d exp=0", pk_pulses - p); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL exact_busy got=%b exp=0", busy); end
    checks++; if (wr_pc[b + 511] !== 16'd1) begin failures++; $display("FAIL exact_wrap_edge got=%0d exp=1", wr_pc[b + 511]); end
  endtask

  task automatic test_clear_mid();
    int b, b2, bad;
    bit ok;
    do_reset();
    enable = 1'b1; usb_full_n = 1'b1;
    b = wr_cnt;
    push_seq(40, 30);
    wait_wr(b + 37, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL clr_writes got=%0d exp=37", wr_cnt - b); end
    usb_full_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    clear = 1'b1;
    @(negedge clk); #1;
    checks++; if (usb_slwr_n !== 1'b1 || usb_pktend_n !== 1'b1) begin failures++; $display("FAIL clr_strobes slwr=%b pktend=%b exp=1/1", usb_slwr_n, usb_pktend_n); end
    checks++; if (usb_fd !== 8'd0) begin failures++; $display("FAIL clr_fd got=%h exp=00", usb_fd); end
    checks++; if (pkt_count !== 16'd0 || busy !== 1'b0) begin failures++; $display("FAIL clr_state pkt=%0d busy=%b exp=0/0", pkt_count, busy); end
    checks++; if (fifo_rdreq !== 1'b0) begin failures++; $display("FAIL clr_rdreq got=%b exp=0", fifo_rdreq); end
    clear = 1'b0; usb_full_n = 1'b1;
    b2 = wr_cnt;
    push_seq(511, 70);
    wait_wr(b2 + 512, 800, ok);
    checks++; if (!ok) begin failures++; $display("FAIL clr_restart_writes got=%0d exp=512", wr_cnt - b2); end
    bad = 0;
    for (int i = 0; i < 512; i++) if (wr_data[b2 + i] !== 8'((69 + i) & 255)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL clr_restart_order bad_bytes=%0d exp=0", bad); end
    checks++; if (wr_pc[b2 + 510] !== 16'd0) begin failures++; $display("FAIL clr_pc_511 got=%0d exp=0", wr_pc[b2 + 510]); end
    checks++; if (wr_pc[b2 + 511] !== 16'd1) begin failures++; $display("FAIL clr_pc_512 got=%0d exp=1", wr_pc[b2 + 511]); end
  endtask

  task automatic test_strobe_exclusive();
    checks++; if (ovl != 0) begin failures++; $display("FAIL strobe_overlap got=%0d exp=0", ovl); end
  endtask

  initial begin
    test_reset();
    test_stream_600();
    test_throughput();
    test_backpressure();
    test_disable_flush();
    test_exact_packet();
    test_clear_mid();
    test_strobe_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t exp=finish_before_limit", $time);
    $fatal(1);
  end

endmodule
